l1_l2_arbiter: RTL and testbench
================================

# l1_l2_arbiter

Parametrised N-requester arbiter between L1 caches (I, D, or more ports) and the shared L2. It replaces the fixed two-port L1I/L1D steering with a registered, round-robin, one-transaction-at-a-time bridge. Winning request attributes are latched for the whole L2 transaction. The L2 completion is returned to the winning requester only, as a one-cycle ready pulse with the line data.

## Interface
Parameters:
- NUM_REQ, 2, number of L1 requesters (≥2); grant width GW = $clog2(NUM_REQ)
- TAG_W, 18, L2 tag width
- INDEX_W, 8, L2 index width
- LINE_W, 512, cache line width

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  asynchronous active-low reset
- flush  in  1  when high, no new grant is issued
- read_req  in  NUM_REQ  per-requester read request (level)
- write_req  in  NUM_REQ  per-requester write-back request (level)
- tag_req  in  NUM_REQ*TAG_W  read tags; requester i at [i*TAG_W +: TAG_W]
- index_req  in  NUM_REQ*INDEX_W  read indices
- write_tag_req  in  NUM_REQ*TAG_W  write-back tags
- write_index_req  in  NUM_REQ*INDEX_W  write-back indices
- write_data_req  in  NUM_REQ*LINE_W  write-back lines
- ready_req  out  NUM_REQ  one-hot completion pulse to the granted requester
- read_data_req  out  LINE_W  line returned by L2, broadcast; valid when any ready_req bit is high
- read_L1_L2  out  1  read to L2
- write_L1_L2  out  1  write-back to L2
- tag_L1_L2 / write_tag_L1_L2  out  TAG_W  latched read / write tag
- index_L1_L2 / write_index_L1_L2  out  INDEX_W  latched read / write index
- write_data_L1_L2  out  LINE_W  latched write-back line
- ready_L2_L1  in  1  L2 completion
- read_data_L2_L1  in  LINE_W  L2 read line
- grant_id  out  GW  index of the current or last granted requester

## Operation
- FSM: IDLE, BUSY, DONE.
- IDLE:
  - Requester i is active when read_req[i] | write_req[i].
  - If flush = 0 and any requester is active: select the first active requester searching ptr, ptr+1, … with wrap mod NUM_REQ.
  - Latch grant_id, both request flags, tags, indices and write data of the winner. Go to BUSY.
- BUSY:
  - Drive read_L1_L2 / write_L1_L2 from the latched flags. Both may be high together (combined write-back plus fill); they are forwarded as is.
  - Latched values do not change while in BUSY.
  - On ready_L2_L1 = 1: capture read_data_L2_L1 into read_data_req, set ready_req = 1 << grant_id, set ptr = (grant_id+1) mod NUM_REQ, go to DONE.
- DONE: one cycle only. read_L1_L2 = write_L1_L2 = 0, ready_req pulse visible. Then go to IDLE.
- Requester rule: a requester deasserts its request on the edge where it samples its ready_req bit. Its request is therefore low in the following IDLE cycle.
- ready_L2_L1 is ignored in IDLE and DONE.
- flush has no effect in BUSY or DONE. A transaction that has started always completes.
- Non-granted requesters wait without a timeout. Their held requests are never dropped.

## Timing
- Reset (nrst low, asynchronous):
  - State = IDLE, ptr = 0, grant_id = 0.
  - ready_req = 0, read_L1_L2 = 0, write_L1_L2 = 0.
  - All tag, index and data outputs = 0.
- A request sampled in IDLE at edge t puts the FSM in BUSY after t, with L2 request outputs high in cycle t+1.
- ready_L2_L1 sampled high at edge t+k (k ≥ 1): DONE in cycle t+k+1 with ready_req and read_data_req valid; IDLE in cycle t+k+2.
- Minimum back-to-back spacing: 3 cycles per transaction.
- Reset asserted mid-BUSY: immediate return to reset values and the transaction is abandoned. After release, arbitration restarts from ptr = 0.
- read_data_req holds its value until the next completion.

## Test plan
- Reset: assert nrst = 0 mid-run with read_req = 2'b11 → all outputs go to reset values within the same cycle. After release, requester 0 is granted first.
- Single read: read_req = 2'b10, tag 0x3ABCD, index 0x5A; L2 ready 4 cycles later with data 0xDEAD… → read_L1_L2 high for cycles t+1..t+5 with tag 0x3ABCD / index 0x5A, then ready_req = 2'b10 for one cycle with read_data_req = 0xDEAD….
- Contention: read_req = 2'b11 held from reset → grant_id sequence 0, 1, 0. ready_req pulses 01, then 10, each after its own L2 completion.
- Fairness, NUM_REQ = 4: all four requesting continuously, L2 ready after 1 cycle → grants 0, 1, 2, 3, 0, with exactly 3 cycles between ready pulses.
- Write-back plus fill: requester 1 sets read_req and write_req with write_tag 0x11111, write_index 0x22, data pattern → both L2 strobes high together with the latched values. Changing the inputs during BUSY does not alter the outputs.
- Flush and stray ready: flush high with read_req = 2'b01 → no grant while flush is high; grant one cycle after flush falls. ready_L2_L1 pulsed in IDLE → no ready_req pulse.

Source files
------------

// File: rtl/l1_l2_arbiter.sv
`timescale 1ns/1ps
// Round-robin bridge from NUM_REQ L1 ports to one shared L2 port.
// Holds the winner's request attributes for the whole L2 transaction.
module l1_l2_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 18,
  parameter int INDEX_W = 8,
  parameter int LINE_W  = 512,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           read_req,
  input  logic [NUM_REQ-1:0]           write_req,
  input  logic [NUM_REQ*TAG_W-1:0]     tag_req,
  input  logic [NUM_REQ*INDEX_W-1:0]   index_req,
  input  logic [NUM_REQ*TAG_W-1:0]     write_tag_req,
  input  logic [NUM_REQ*INDEX_W-1:0]   write_index_req,
  input  logic [NUM_REQ*LINE_W-1:0]    write_data_req,
  output logic [NUM_REQ-1:0]           ready_req,
  output logic [LINE_W-1:0]            read_data_req,
  output logic                         read_L1_L2,
  output logic                         write_L1_L2,
  output logic [TAG_W-1:0]             tag_L1_L2,
  output logic [TAG_W-1:0]             write_tag_L1_L2,
  output logic [INDEX_W-1:0]           index_L1_L2,
  output logic [INDEX_W-1:0]           write_index_L1_L2,
  output logic [LINE_W-1:0]            write_data_L1_L2,
  input  logic                         ready_L2_L1,
  input  logic [LINE_W-1:0]            read_data_L2_L1,
  output logic [GW-1:0]                grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [GW-1:0]        r_ptr, r_grant;
  logic                 r_rd, r_wr;
  logic [TAG_W-1:0]     r_tag, r_wtag;
  logic [INDEX_W-1:0]   r_idx, r_widx;
  logic [LINE_W-1:0]    r_wdat, r_rdata;

  logic [NUM_REQ-1:0]   w_act;
  logic                 w_any;
  logic [GW-1:0]        w_win, w_cand;
  logic                 w_take;
  int                   w_idx;

  assign w_act = read_req | write_req;

  // Scan from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    w_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = GW'(w_idx);
      if (w_act[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && !flush && w_any;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_BUSY;
      S_BUSY:  if (ready_L2_L1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_tag   <= '0;
      r_wtag  <= '0;
      r_idx   <= '0;
      r_widx  <= '0;
      r_wdat  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_grant <= w_win;
        r_rd    <= read_req[w_win];
        r_wr    <= write_req[w_win];
        r_tag   <= tag_req[w_win*TAG_W +: TAG_W];
        r_idx   <= index_req[w_win*INDEX_W +: INDEX_W];
        r_wtag  <= write_tag_req[w_win*TAG_W +: TAG_W];
        r_widx  <= write_index_req[w_win*INDEX_W +: INDEX_W];
        r_wdat  <= write_data_req[w_win*LINE_W +: LINE_W];
      end
      // Completion: return data and move priority past the served requester.
      if (r_state == S_BUSY && ready_L2_L1) begin
        r_rdata <= read_data_L2_L1;
        r_ptr   <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  assign read_L1_L2        = (r_state == S_BUSY) && r_rd;
  assign write_L1_L2       = (r_state == S_BUSY) && r_wr;
  assign ready_req         = (r_state == S_DONE) ? (NUM_REQ'(1) << r_grant) : '0;
  assign read_data_req     = r_rdata;
  assign tag_L1_L2         = r_tag;
  assign index_L1_L2       = r_idx;
  assign write_tag_L1_L2   = r_wtag;
  assign write_index_L1_L2 = r_widx;
  assign write_data_L1_L2  = r_wdat;
  assign grant_id          = r_grant;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
`timescale 1ns/1ps
// Bench for l1_l2_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference; a 4-port instance checks round-robin fairness.
module tb_l1_l2_arbiter;
  localparam int TW = 18, IW = 8, LW = 512;

  logic clk = 1'b0, nrst = 1'b0;
  always #5 clk = ~clk;

  // 2-port instance
  logic f2, rdy2;
  logic [1:0] rd2, wr2, rq2;
  logic [2*TW-1:0] tg2, wtg2;
  logic [2*IW-1:0] ix2, wix2;
  logic [2*LW-1:0] wd2;
  logic [LW-1:0] l2d2, rdd2, owd2;
  logic or2, ow2;
  logic [TW-1:0] otg2, owtg2;
  logic [IW-1:0] oix2, owix2;
  logic [0:0] gid2;

  // 4-port instance
  logic f4, rdy4;
  logic [3:0] rd4, wr4, rq4;
  logic [4*TW-1:0] tg4, wtg4;
  logic [4*IW-1:0] ix4, wix4;
  logic [4*LW-1:0] wd4;
  logic [LW-1:0] l2d4, rdd4, owd4;
  logic or4, ow4;
  logic [TW-1:0] otg4, owtg4;
  logic [IW-1:0] oix4, owix4;
  logic [1:0] gid4;

  l1_l2_arbiter #(.NUM_REQ(2), .TAG_W(TW), .INDEX_W(IW), .LINE_W(LW)) dut2 (
    .clk(clk), .nrst(nrst), .flush(f2), .read_req(rd2), .write_req(wr2),
    .tag_req(tg2), .index_req(ix2), .write_tag_req(wtg2), .write_index_req(wix2),
    .write_data_req(wd2), .ready_req(rq2), .read_data_req(rdd2),
    .read_L1_L2(or2), .write_L1_L2(ow2), .tag_L1_L2(otg2), .write_tag_L1_L2(owtg2),
    .index_L1_L2(oix2), .write_index_L1_L2(owix2), .write_data_L1_L2(owd2),
    .ready_L2_L1(rdy2), .read_data_L2_L1(l2d2), .grant_id(gid2));

  l1_l2_arbiter #(.NUM_REQ(4), .TAG_W(TW), .INDEX_W(IW), .LINE_W(LW)) dut4 (
    .clk(clk), .nrst(nrst), .flush(f4), .read_req(rd4), .write_req(wr4),
    .tag_req(tg4), .index_req(ix4), .write_tag_req(wtg4), .write_index_req(wix4),
    .write_data_req(wd4), .ready_req(rq4), .read_data_req(rdd4),
    .read_L1_L2(or4), .write_L1_L2(ow4), .tag_L1_L2(otg4), .write_tag_L1_L2(owtg4),
    .index_L1_L2(oix4), .write_index_L1_L2(owix4), .write_data_L1_L2(owd4),
    .ready_L2_L1(rdy4), .read_data_L2_L1(l2d4), .grant_id(gid4));

  int n_cmp = 0, n_fail = 0;

  // Transaction-level reference for the 2-port instance.
  // m_phase: 0 = no transaction, 1 = transaction open at L2, 2 = completion pulse
  int m_phase, m_ptr, m_gid;
  logic m_rd, m_wr;
  logic [TW-1:0] m_tag, m_wtag;
  logic [IW-1:0] m_idx, m_widx;
  logic [LW-1:0] m_wdat, m_rdata;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_gid = 0; m_rd = 0; m_wr = 0;
    m_tag = '0; m_wtag = '0; m_idx = '0; m_widx = '0; m_wdat = '0; m_rdata = '0;
  endtask

  // Advance reference on the inputs present before the edge, clock once,
  // then apply the requester rule (drop request after seeing its ready pulse).
  task automatic tick2();
    int w;
    w = -1;
    case (m_phase)
      0: if (!f2) begin
        for (int k = 0; k < 2; k++) begin
          int i = (m_ptr + k) % 2;
          if (w < 0 && (rd2[i] | wr2[i])) w = i;
        end
        if (w >= 0) begin
          m_gid = w; m_rd = rd2[w]; m_wr = wr2[w];
          m_tag = tg2[w*TW +: TW]; m_idx = ix2[w*IW +: IW];
          m_wtag = wtg2[w*TW +: TW]; m_widx = wix2[w*IW +: IW];
          m_wdat = wd2[w*LW +: LW];
          m_phase = 1;
        end
      end
      1: if (rdy2) begin
        m_rdata = l2d2; m_ptr = (m_gid + 1) % 2; m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    @(posedge clk); #1;
    if (m_phase == 2) begin rd2[m_gid] = 1'b0; wr2[m_gid] = 1'b0; end
  endtask

  task automatic test_reset_state();
    n_cmp++; if (rq2 !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", rq2); end
    n_cmp++; if ({or2, ow2} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got=%b exp=00", {or2, ow2}); end
    n_cmp++; if (gid2 !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%0d exp=0", gid2); end
    n_cmp++; if ({otg2, oix2, owtg2, owix2} !== '0) begin n_fail++; $display("FAIL rst_tagidx got=%h exp=0", {otg2, oix2, owtg2, owix2}); end
    n_cmp++; if ({rdd2, owd2} !== '0) begin n_fail++; $display("FAIL rst_data got nonzero exp=0"); end
    n_cmp++; if ({rq4, or4, ow4, gid4} !== '0) begin n_fail++; $display("FAIL rst_dut4 got=%b exp=0", {rq4, or4, ow4, gid4}); end
  endtask

  task automatic test_contention();
    logic [LW-1:0] d;
    logic [1:0] e_rq;
    int e_g;
    rd2 = 2'b11; wr2 = 2'b00;
    for (int t = 0; t < 3; t++) begin
      e_g = (t == 1) ? 1 : 0;
      e_rq = (t == 1) ? 2'b10 : 2'b01;
      tg2 = {TW'($urandom), TW'($urandom)};
      tick2();
      rd2 = 2'b11;
      n_cmp++; if (gid2 !== 1'(e_g)) begin n_fail++; $display("FAIL cont_grant t=%0d got=%0d exp=%0d", t, gid2, e_g); end
      n_cmp++; if (or2 !== 1'b1) begin n_fail++; $display("FAIL cont_read t=%0d got=%b exp=1", t, or2); end
      n_cmp++; if (otg2 !== tg2[e_g*TW +: TW]) begin n_fail++; $display("FAIL cont_tag t=%0d got=%h exp=%h", t, otg2, tg2[e_g*TW +: TW]); end
      repeat ($urandom_range(0, 3)) begin
        tick2();
        n_cmp++; if (rq2 !== 2'b00) begin n_fail++; $display("FAIL cont_early_ready t=%0d got=%b exp=00", t, rq2); end
      end
      d = rand_line(); l2d2 = d; rdy2 = 1'b1;
      tick2();
      rdy2 = 1'b0;
      n_cmp++; if (rq2 !== e_rq) begin n_fail++; $display("FAIL cont_ready t=%0d got=%b exp=%b", t, rq2, e_rq); end
      n_cmp++; if (rdd2 !== d) begin n_fail++; $display("FAIL cont_rdata t=%0d got=%h exp=%h", t, rdd2, d); end
      tick2();
      n_cmp++; if (rq2 !== 2'b00) begin n_fail++; $display("FAIL cont_pulse_len t=%0d got=%b exp=00", t, rq2); end
    end
  endtask

  task automatic test_reset();
    rd2 = 2'b11; wr2 = 2'b01;
    tg2 = {18'h2AAAA, 18'h15555}; ix2 = {8'hC3, 8'h3C};
    tick2();
    n_cmp++; if (gid2 !== 1'b1 || or2 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got gid=%0d rd=%b exp gid=1 rd=1", gid2, or2); end
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if ({rq2, or2, ow2, gid2} !== '0) begin n_fail++; $display("FAIL rstmid_ctrl got=%b exp=0", {rq2, or2, ow2, gid2}); end
    n_cmp++; if ({otg2, oix2, owtg2, owix2} !== '0) begin n_fail++; $display("FAIL rstmid_tagidx got=%h exp=0", {otg2, oix2, owtg2, owix2}); end
    n_cmp++; if ({rdd2, owd2} !== '0) begin n_fail++; $display("FAIL rstmid_data got nonzero exp=0"); end
    model_reset();
    @(posedge clk); #1 nrst = 1'b1;
    tick2();
    n_cmp++; if (gid2 !== 1'b0 || or2 !== 1'b1 || otg2 !== 18'h15555) begin
      n_fail++; $display("FAIL rstmid_regrant got gid=%0d rd=%b tag=%h exp gid=0 rd=1 tag=15555", gid2, or2, otg2); end
    rdy2 = 1'b1; l2d2 = rand_line();
    tick2();
    rdy2 = 1'b0;
    tick2();
  endtask

  task automatic test_single_read();
    logic [LW-1:0] dead;
    dead = {16{32'hDEADBEEF}};
    rd2 = 2'b10; wr2 = 2'b00;
    tg2 = {18'h3ABCD, TW'($urandom)}; ix2 = {8'h5A, IW'($urandom)};
    tick2();
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (or2 !== 1'b1 || ow2 !== 1'b0 || rq2 !== 2'b00) begin
        n_fail++; $display("FAIL single_strobe c=%0d got rd=%b wr=%b rq=%b exp 1 0 00", c, or2, ow2, rq2); end
      n_cmp++; if (otg2 !== 18'h3ABCD || oix2 !== 8'h5A) begin
        n_fail++; $display("FAIL single_addr c=%0d got tag=%h idx=%h exp 3abcd 5a", c, otg2, oix2); end
      if (c == 5) begin rdy2 = 1'b1; l2d2 = dead; end
      tick2();
    end
    rdy2 = 1'b0;
    n_cmp++; if (rq2 !== 2'b10 || or2 !== 1'b0) begin n_fail++; $display("FAIL single_ready got rq=%b rd=%b exp 10 0", rq2, or2); end
    n_cmp++; if (rdd2 !== dead) begin n_fail++; $display("FAIL single_rdata got=%h exp=%h", rdd2, dead); end
    l2d2 = rand_line();
    tick2();
    n_cmp++; if (rq2 !== 2'b00 || rdd2 !== dead) begin n_fail++; $display("FAIL single_hold got rq=%b data changed=%b exp 00 0", rq2, rdd2 !== dead); end
  endtask

  task automatic test_wb_fill();
    logic [LW-1:0] pat;
    logic [TW-1:0] rt;
    pat = rand_line(); rt = TW'($urandom);
    rd2 = 2'b10; wr2 = 2'b10;
    tg2 = {rt, TW'($urandom)}; wtg2 = {18'h11111, TW'($urandom)};
    wix2 = {8'h22, IW'($urandom)}; wd2 = {pat, rand_line()};
    tick2();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (or2 !== 1'b1 || ow2 !== 1'b1) begin n_fail++; $display("FAIL wb_strobes c=%0d got rd=%b wr=%b exp 1 1", c, or2, ow2); end
      n_cmp++; if (owtg2 !== 18'h11111 || owix2 !== 8'h22 || otg2 !== rt) begin
        n_fail++; $display("FAIL wb_addr c=%0d got wt=%h wi=%h t=%h exp 11111 22 %h", c, owtg2, owix2, otg2, rt); end
      n_cmp++; if (owd2 !== pat) begin n_fail++; $display("FAIL wb_data c=%0d got=%h exp=%h", c, owd2, pat); end
      tg2 = {TW'($urandom), TW'($urandom)}; wtg2 = {TW'($urandom), TW'($urandom)};
      wix2 = {IW'($urandom), IW'($urandom)}; wd2 = {rand_line(), rand_line()};
      if (c == 2) rdy2 = 1'b1;
      tick2();
    end
    rdy2 = 1'b0;
    n_cmp++; if ({or2, ow2} !== 2'b00 || rq2 !== 2'b10) begin n_fail++; $display("FAIL wb_done got strobes=%b rq=%b exp 00 10", {or2, ow2}, rq2); end
    tick2();
  endtask

  task automatic test_flush_stray();
    logic [LW-1:0] keep;
    rd2 = 2'b01; wr2 = 2'b00; f2 = 1'b1;
    repeat (3) begin
      tick2();
      n_cmp++; if (or2 !== 1'b0 || rq2 !== 2'b00) begin n_fail++; $display("FAIL flush_hold got rd=%b rq=%b exp 0 00", or2, rq2); end
    end
    f2 = 1'b0;
    tick2();
    n_cmp++; if (or2 !== 1'b1 || gid2 !== 1'b0) begin n_fail++; $display("FAIL flush_release got rd=%b gid=%0d exp 1 0", or2, gid2); end
    f2 = 1'b1; rdy2 = 1'b1; keep = rand_line(); l2d2 = keep;
    tick2();
    n_cmp++; if (rq2 !== 2'b01) begin n_fail++; $display("FAIL flush_in_busy got rq=%b exp 01", rq2); end
    f2 = 1'b0; rdy2 = 1'b0;
    tick2();
    rdy2 = 1'b1;
    repeat (3) begin
      l2d2 = rand_line();
      tick2();
      n_cmp++; if (rq2 !== 2'b00 || rdd2 !== keep) begin n_fail++; $display("FAIL stray_ready got rq=%b data changed=%b exp 00 0", rq2, rdd2 !== keep); end
    end
    rdy2 = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] hold, st;
    logic e_rd, e_wr;
    logic [1:0] e_rq;
    hold = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(rd2[i] | wr2[i]) && !hold[i] && $urandom_range(0, 2) == 0) begin
          st = 2'($urandom_range(1, 3)); rd2[i] = st[0]; wr2[i] = st[1];
        end
      end
      tg2 = {TW'($urandom), TW'($urandom)}; ix2 = {IW'($urandom), IW'($urandom)};
      wtg2 = {TW'($urandom), TW'($urandom)}; wix2 = {IW'($urandom), IW'($urandom)};
      wd2 = {rand_line(), rand_line()}; l2d2 = rand_line();
      f2 = ($urandom_range(0, 7) == 0); rdy2 = ($urandom_range(0, 2) == 0);
      tick2();
      hold = (m_phase == 2) ? (2'b01 << m_gid) : 2'b00;
      e_rd = (m_phase == 1) && m_rd;
      e_wr = (m_phase == 1) && m_wr;
      e_rq = (m_phase == 2) ? (2'b01 << m_gid) : 2'b00;
      n_cmp++; if (or2 !== e_rd || ow2 !== e_wr) begin n_fail++; $display("FAIL rnd_strobes c=%0d got=%b%b exp=%b%b", c, or2, ow2, e_rd, e_wr); end
      n_cmp++; if (rq2 !== e_rq) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, rq2, e_rq); end
      n_cmp++; if (gid2 !== 1'(m_gid)) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%0d exp=%0d", c, gid2, m_gid); end
      n_cmp++; if ({otg2, oix2, owtg2, owix2} !== {m_tag, m_idx, m_wtag, m_widx}) begin
        n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, {otg2, oix2, owtg2, owix2}, {m_tag, m_idx, m_wtag, m_widx}); end
      n_cmp++; if (owd2 !== m_wdat) begin n_fail++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, owd2, m_wdat); end
      n_cmp++; if (rdd2 !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdd2, m_rdata); end
    end
    rd2 = 2'b00; wr2 = 2'b00; f2 = 1'b0; rdy2 = 1'b1;
    for (int i = 0; i < 4 && m_phase != 0; i++) tick2();
    rdy2 = 1'b0;
    n_cmp++; if ({or2, ow2, rq2} !== '0) begin n_fail++; $display("FAIL rnd_drain got=%b exp=0", {or2, ow2, rq2}); end
  endtask

  task automatic test_fairness();
    int np, last;
    logic [3:0] raise, e4;
    np = 0; last = 0; raise = 4'b0000;
    rd4 = 4'hF; rdy4 = 1'b1;
    for (int c = 0; c < 60 && np < 5; c++) begin
      @(posedge clk); #1;
      rd4 = rd4 | raise; raise = 4'b0000;
      if (rq4 !== 4'b0000) begin
        e4 = 4'b0001 << (np % 4);
        n_cmp++; if (rq4 !== e4) begin n_fail++; $display("FAIL fair_ready n=%0d got=%b exp=%b", np, rq4, e4); end
        n_cmp++; if (gid4 !== 2'(np % 4)) begin n_fail++; $display("FAIL fair_grant n=%0d got=%0d exp=%0d", np, gid4, np % 4); end
        if (np > 0) begin
          n_cmp++; if (c - last != 3) begin n_fail++; $display("FAIL fair_spacing n=%0d got=%0d exp=3", np, c - last); end
        end
        rd4 = rd4 & ~rq4; raise = rq4; last = c; np++;
      end
    end
    n_cmp++; if (np < 5) begin n_fail++; $display("FAIL fair_timeout got=%0d pulses exp=5", np); end
    rd4 = 4'h0; rdy4 = 1'b0;
  endtask

  initial begin
    f2 = 0; rdy2 = 0; rd2 = 0; wr2 = 0; tg2 = '0; wtg2 = '0; ix2 = '0; wix2 = '0; wd2 = '0; l2d2 = '0;
    f4 = 0; rdy4 = 0; rd4 = 0; wr4 = 0; tg4 = '0; wtg4 = '0; ix4 = '0; wix4 = '0; wd4 = '0; l2d4 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    test_reset_state();
    test_contention();
    test_reset();
    rd2 = 2'b00; wr2 = 2'b00;
    test_single_read();
    rd2 = 2'b00; wr2 = 2'b00;
    test_wb_fill();
    rd2 = 2'b00; wr2 = 2'b00;
    test_flush_stray();
    rd2 = 2'b00; wr2 = 2'b00;
    test_random();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
